// File: rtl/cpu_run_monitor_if.sv
// rtl/cpu_run_monitor_if.sv - CPU-side bus between a simulated CPU and its run monitor
interface cpu_run_monitor_if #(
    parameter int PC_WIDTH   = 32,
    parameter int DATA_WIDTH = 32
);
    logic [PC_WIDTH-1:0]   pc;
    logic                  wb_en;
    logic [4:0]            wb_addr;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  cpu_reset;

    modport master (output pc, output wb_en, output wb_addr, output wb_data, input cpu_reset);
    modport slave  (input pc, input wb_en, input wb_addr, input wb_data, output cpu_reset);
endinterface

// File: rtl/cpu_run_monitor.sv
// rtl/cpu_run_monitor.sv - CPU reset sequencer, halt/timeout detector and writeback signature
module cpu_run_monitor #(
    parameter int                    PC_WIDTH     = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    RESET_CYCLES = 2,
    parameter int                    HALT_REPEAT  = 3,
    parameter int                    MAX_CYCLES   = 64,
    parameter logic [DATA_WIDTH-1:0] SIG_SEED     = '0,
    parameter logic [DATA_WIDTH-1:0] EXPECTED_SIG = '0,
    localparam int                   CNT_W        = $clog2(MAX_CYCLES + 1)
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    cpu_run_monitor_if.slave      i_cpu,
    output logic                  o_running,
    output logic                  o_done,
    output logic                  o_pass,
    output logic                  o_timeout,
    output logic [CNT_W-1:0]      o_cycle_count,
    output logic [CNT_W-1:0]      o_wb_count,
    output logic [DATA_WIDTH-1:0] o_signature
);

    localparam int HOLD_W = $clog2(RESET_CYCLES + 1);
    localparam int STB_W  = $clog2(HALT_REPEAT + 1);

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_RUN     = 2'd1,
        S_HALTED  = 2'd2,
        S_TIMEOUT = 2'd3
    } state_t;

    state_t                r_state;
    logic [HOLD_W-1:0]     r_hold_cnt;
    logic                  r_cpu_reset;
    logic [CNT_W-1:0]      r_cycle_count;
    logic [CNT_W-1:0]      r_wb_count;
    logic [DATA_WIDTH-1:0] r_signature;
    logic [PC_WIDTH-1:0]   r_prev_pc;
    logic                  r_prev_valid;
    logic [STB_W-1:0]      r_stable;

    state_t                w_state_nx;
    logic [HOLD_W-1:0]     w_hold_nx;
    logic                  w_cpu_reset_nx;
    logic [CNT_W-1:0]      w_cycle_nx;
    logic [CNT_W-1:0]      w_wb_nx;
    logic [DATA_WIDTH-1:0] w_sig_nx;
    logic [PC_WIDTH-1:0]   w_prev_pc_nx;
    logic                  w_prev_valid_nx;
    logic [STB_W-1:0]      w_stable_nx;
    logic [HOLD_W-1:0]     w_hold_inc;
    logic [CNT_W-1:0]      w_cycle_inc;
    logic [STB_W-1:0]      w_stable_inc;
    logic                  w_same_pc;
    logic                  w_wb_hit;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state       <= S_HOLD;
            r_hold_cnt    <= '0;
            r_cpu_reset   <= 1'b0;
            r_cycle_count <= '0;
            r_wb_count    <= '0;
            r_signature   <= SIG_SEED;
            r_prev_pc     <= '0;
            r_prev_valid  <= 1'b0;
            r_stable      <= '0;
        end else begin
            r_state       <= w_state_nx;
            r_hold_cnt    <= w_hold_nx;
            r_cpu_reset   <= w_cpu_reset_nx;
            r_cycle_count <= w_cycle_nx;
            r_wb_count    <= w_wb_nx;
            r_signature   <= w_sig_nx;
            r_prev_pc     <= w_prev_pc_nx;
            r_prev_valid  <= w_prev_valid_nx;
            r_stable      <= w_stable_nx;
        end
    end

    always_comb begin
        w_state_nx      = r_state;
        w_hold_nx       = r_hold_cnt;
        w_cpu_reset_nx  = r_cpu_reset;
        w_cycle_nx      = r_cycle_count;
        w_wb_nx         = r_wb_count;
        w_sig_nx        = r_signature;
        w_prev_pc_nx    = r_prev_pc;
        w_prev_valid_nx = r_prev_valid;
        w_stable_nx     = r_stable;
        w_hold_inc      = r_hold_cnt + 1'b1;
        w_cycle_inc     = r_cycle_count + 1'b1;
        w_stable_inc    = r_stable + 1'b1;
        w_same_pc       = r_prev_valid && (i_cpu.pc == r_prev_pc);
        w_wb_hit        = i_cpu.wb_en && (i_cpu.wb_addr != 5'd0);

        case (r_state)
            S_HOLD: begin
                w_hold_nx = w_hold_inc;
                if (w_hold_inc == HOLD_W'(RESET_CYCLES)) begin
                    w_state_nx     = S_RUN;
                    w_cpu_reset_nx = 1'b1;
                end
            end
            S_RUN: begin
                w_cycle_nx      = w_cycle_inc;
                w_prev_pc_nx    = i_cpu.pc;
                w_prev_valid_nx = 1'b1;
                w_stable_nx     = w_same_pc ? w_stable_inc : '0;
                if (w_wb_hit) begin
                    if (r_wb_count != {CNT_W{1'b1}}) begin
                        w_wb_nx = r_wb_count + 1'b1;
                    end
                    w_sig_nx = {r_signature[DATA_WIDTH-2:0], r_signature[DATA_WIDTH-1]}
                               ^ i_cpu.wb_data
                               ^ {{(DATA_WIDTH-5){1'b0}}, i_cpu.wb_addr};
                end
                if (w_same_pc && (w_stable_inc == STB_W'(HALT_REPEAT))) begin
                    w_state_nx = S_HALTED;
                end else if (w_cycle_inc == CNT_W'(MAX_CYCLES)) begin
                    w_state_nx = S_TIMEOUT;
                end
            end
            default: begin
            end
        endcase
    end

    assign i_cpu.cpu_reset = r_cpu_reset;
    assign o_running       = (r_state == S_RUN);
    assign o_done          = (r_state == S_HALTED) || (r_state == S_TIMEOUT);
    assign o_pass          = (r_state == S_HALTED) && (r_signature == EXPECTED_SIG);
    assign o_timeout       = (r_state == S_TIMEOUT);
    assign o_cycle_count   = r_cycle_count;
    assign o_wb_count      = r_wb_count;
    assign o_signature     = r_signature;

endmodule
